// File: rtl/peripheral_encoder.sv
// Dual-motor quadrature encoder peripheral: x4 decode into wrapping position
// counters, windowed signed speed measurement, and a register map on the J1 I/O bus.
module peripheral_encoder #(
    parameter logic [15:0] WINDOW_RST = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic [1:0]  enc_a,
    input  logic [1:0]  enc_b
);

    localparam logic [3:0] ADDR_COUNT1  = 4'h0;
    localparam logic [3:0] ADDR_COUNT2  = 4'h2;
    localparam logic [3:0] ADDR_STATUS  = 4'h4;
    localparam logic [3:0] ADDR_CONTROL = 4'h6;
    localparam logic [3:0] ADDR_WINDOW  = 4'h8;
    localparam logic [3:0] ADDR_SPEED1  = 4'hA;
    localparam logic [3:0] ADDR_SPEED2  = 4'hC;

    logic [1:0]  r_sync1_a;
    logic [1:0]  r_sync2_a;
    logic [1:0]  r_sync1_b;
    logic [1:0]  r_sync2_b;
    logic [1:0]  r_prev_a;
    logic [1:0]  r_prev_b;
    logic [1:0]  r_arm;

    logic [15:0] r_count [2];
    logic [15:0] r_acc   [2];
    logic [15:0] r_speed [2];
    logic [1:0]  r_err;
    logic [1:0]  r_dir;
    logic [15:0] r_window;
    logic [15:0] r_win_cnt;

    logic [1:0]  w_fwd;
    logic [1:0]  w_rev;
    logic [1:0]  w_ill;
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_ctrl_wr;
    logic        w_win_wr;
    logic [1:0]  w_clr_cnt;
    logic        w_clr_err;
    logic        w_clr_spd;
    logic        w_win_zero;
    logic        w_win_end;

    function automatic logic [15:0] f_sat_step(input logic [15:0] acc,
                                               input logic        up,
                                               input logic        dn);
        logic [15:0] res;
        res = acc;
        if (up && (acc != 16'h7FFF)) begin
            res = acc + 16'd1;
        end else if (dn && (acc != 16'h8000)) begin
            res = acc - 16'd1;
        end
        return res;
    endfunction

    // Bus decode; a simultaneous rd is suppressed whenever wr is present.
    assign w_wr_en    = cs && wr;
    assign w_rd_en    = cs && rd && !wr;
    assign w_ctrl_wr  = w_wr_en && (addr == ADDR_CONTROL);
    assign w_win_wr   = w_wr_en && (addr == ADDR_WINDOW);
    assign w_clr_cnt  = w_ctrl_wr ? d_in[1:0] : 2'b00;
    assign w_clr_err  = w_ctrl_wr && d_in[2];
    assign w_clr_spd  = w_ctrl_wr && d_in[3];
    assign w_win_zero = (r_window == 16'h0000);
    assign w_win_end  = !w_win_zero && (r_win_cnt == (r_window - 16'd1));

    // r_arm holds decoding off until r_prev carries a fully synchronized sample,
    // so encoder levels present at reset release never produce a count or error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1_a <= 2'b00;
            r_sync2_a <= 2'b00;
            r_sync1_b <= 2'b00;
            r_sync2_b <= 2'b00;
            r_prev_a  <= 2'b00;
            r_prev_b  <= 2'b00;
            r_arm     <= 2'd0;
        end else begin
            r_sync1_a <= enc_a;
            r_sync2_a <= r_sync1_a;
            r_sync1_b <= enc_b;
            r_sync2_b <= r_sync1_b;
            r_prev_a  <= r_sync2_a;
            r_prev_b  <= r_sync2_b;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    always_comb begin
        w_fwd = 2'b00;
        w_rev = 2'b00;
        w_ill = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (r_arm == 2'd3) begin
                case ({r_prev_a[i], r_prev_b[i], r_sync2_a[i], r_sync2_b[i]})
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd[i] = 1'b1;
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rev[i] = 1'b1;
                    4'b0011, 4'b1100, 4'b1001, 4'b0110: w_ill[i] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Position, sticky error and direction; a control clear beats a same-cycle step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_count[i] <= 16'h0000;
            end
            r_err <= 2'b00;
            r_dir <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_clr_cnt[i]) begin
                    r_count[i] <= 16'h0000;
                end else if (w_fwd[i]) begin
                    r_count[i] <= r_count[i] + 16'd1;
                end else if (w_rev[i]) begin
                    r_count[i] <= r_count[i] - 16'd1;
                end

                if (w_clr_err) begin
                    r_err[i] <= 1'b0;
                end else if (w_ill[i]) begin
                    r_err[i] <= 1'b1;
                end

                if (w_fwd[i]) begin
                    r_dir[i] <= 1'b0;
                end else if (w_rev[i]) begin
                    r_dir[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window  <= WINDOW_RST;
            r_win_cnt <= 16'h0000;
        end else if (w_win_wr) begin
            r_window  <= d_in;
            r_win_cnt <= 16'h0000;
        end else if (w_win_zero || w_win_end) begin
            r_win_cnt <= 16'h0000;
        end else begin
            r_win_cnt <= r_win_cnt + 16'd1;
        end
    end

    // The window-end load folds in a step landing on that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_acc[i]   <= 16'h0000;
                r_speed[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_clr_spd) begin
                    r_speed[i] <= 16'h0000;
                end else if (w_win_end && !w_win_wr) begin
                    r_speed[i] <= f_sat_step(r_acc[i], w_fwd[i], w_rev[i]);
                end

                if (w_win_wr || w_clr_spd || w_win_zero || w_win_end) begin
                    r_acc[i] <= 16'h0000;
                end else begin
                    r_acc[i] <= f_sat_step(r_acc[i], w_fwd[i], w_rev[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= 16'h0000;
        end else if (w_rd_en) begin
            case (addr)
                ADDR_COUNT1: d_out <= r_count[0];
                ADDR_COUNT2: d_out <= r_count[1];
                ADDR_STATUS: d_out <= {12'h000, r_dir[1], r_dir[0], r_err[1], r_err[0]};
                ADDR_WINDOW: d_out <= r_window;
                ADDR_SPEED1: d_out <= r_speed[0];
                ADDR_SPEED2: d_out <= r_speed[1];
                default:     d_out <= 16'h0000;
            endcase
        end else begin
            d_out <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_peripheral_encoder.sv
// Directed and randomized bench for peripheral_encoder against a phase-based
// encoder model that tracks expected positions, errors, directions and speeds.
module tb_peripheral_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic [1:0]  enc_a;
    logic [1:0]  enc_b;

    int          checks   = 0;
    int          failures = 0;

    int          phase   [2];
    logic [15:0] exp_cnt [2];
    logic        exp_err [2];
    logic        exp_dir [2];

    always #5 clk = ~clk;

    peripheral_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .enc_a (enc_a),
        .enc_b (enc_b)
    );

    // Quadrature position 0..3 -> {A,B}; forward is increasing position.
    function automatic logic [1:0] ab_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [15:0] exp_status();
        return {12'h000, exp_dir[1], exp_dir[0], exp_err[1], exp_err[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enc();
        logic [1:0] ab;
        for (int i = 0; i < 2; i++) begin
            ab = ab_of(phase[i]);
            enc_a[i] = ab[1];
            enc_b[i] = ab[0];
        end
    endtask

    task automatic move(input int m, input int dir);
        phase[m]   = (phase[m] + dir) & 3;
        exp_cnt[m] = exp_cnt[m] + 16'(dir);
        exp_dir[m] = (dir < 0);
        drive_enc();
    endtask

    task automatic illegal_move(input int m);
        phase[m]   = (phase[m] + 2) & 3;
        exp_err[m] = 1'b1;
        drive_enc();
    endtask

    task automatic step(input int m, input int dir, input int hold);
        move(m, dir);
        repeat (hold) tick();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_read(input logic [3:0] a, output logic [15:0] v);
        addr = a;
        cs   = 1'b1;
        rd   = 1'b1;
        tick();
        v    = d_out;
        cs   = 1'b0;
        rd   = 1'b0;
    endtask

    task automatic read_check(input logic [3:0] a, input string tag, input logic [15:0] expv);
        logic [15:0] v;
        do_read(a, v);
        check(tag, v, expv);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        addr = a;
        d_in = d;
        cs   = 1'b1;
        wr   = 1'b1;
        tick();
        cs   = 1'b0;
        wr   = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_cnt[i] = 16'h0000;
            exp_err[i] = 1'b0;
            exp_dir[i] = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] old_cnt;
        logic [15:0] spd0;
        logic [15:0] spd1;
        int          n;
        int          d0;
        int          d1;
        int          sum0;
        int          sum1;

        rst  = 1'b1;
        d_in = 16'h0000;
        cs   = 1'b0;
        addr = 4'h0;
        rd   = 1'b0;
        wr   = 1'b0;
        phase[0] = 0;
        phase[1] = 0;
        drive_enc();
        model_reset();
        repeat (3) tick();
        check("dout_in_reset", d_out, 16'h0000);
        rst = 1'b0;
        repeat (5) tick();

        read_check(4'h0, "rst_count1", 16'h0000);
        read_check(4'h2, "rst_count2", 16'h0000);
        read_check(4'h4, "rst_status", 16'h0000);
        read_check(4'h8, "rst_window", 16'd50000);
        read_check(4'hA, "rst_speed1", 16'h0000);
        tick();
        check("dout_idle_zero", d_out, 16'h0000);

        // Forward drive on motor 1
        for (int k = 0; k < 8; k++) step(0, 1, 2);
        repeat (4) tick();
        read_check(4'h0, "fwd8_count1", 16'h0008);
        read_check(4'h4, "fwd8_status", exp_status());

        // Illegal double-bit transition, then clear errors
        illegal_move(0);
        repeat (5) tick();
        read_check(4'h0, "illegal_count1", exp_cnt[0]);
        read_check(4'h4, "illegal_status", 16'h0001);
        read_check(4'h4, "status_not_cleared_by_read", 16'h0001);
        do_write(4'h6, 16'h0004);
        exp_err[0] = 1'b0;
        read_check(4'h4, "err_cleared_status", 16'h0000);

        // Reverse steps on motor 2 wrap below zero
        for (int k = 0; k < 3; k++) step(1, -1, 2);
        repeat (4) tick();
        read_check(4'h2, "rev3_count2", 16'hFFFD);
        read_check(4'h4, "rev3_status", exp_status());

        // Writes to read-only/unmapped addresses and reads of write-only/unmapped
        do_write(4'h0, 16'h1234);
        do_write(4'hE, 16'hFFFF);
        read_check(4'h0, "ro_write_count1", exp_cnt[0]);
        read_check(4'h6, "read_control_zero", 16'h0000);
        read_check(4'hE, "read_unmapped_zero", 16'h0000);

        // rd and wr together: write only, d_out forced to zero
        addr = 4'h8;
        d_in = 16'd300;
        cs   = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;
        tick();
        check("rdwr_dout_zero", d_out, 16'h0000);
        cs = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        read_check(4'h8, "rdwr_window", 16'd300);

        // Read coinciding with the count update returns the old value
        old_cnt = exp_cnt[0];
        move(0, 1);
        tick();
        tick();
        read_check(4'h0, "coincide_read_old", old_cnt);
        read_check(4'h0, "coincide_read_new", exp_cnt[0]);

        // Control clear on the same edge as a step wins
        move(0, 1);
        tick();
        tick();
        do_write(4'h6, 16'h0001);
        exp_cnt[0] = 16'h0000;
        repeat (3) tick();
        read_check(4'h0, "clear_beats_step", 16'h0000);

        // Positive wrap of count1
        for (int k = 0; k < 32767; k++) step(0, 1, 1);
        repeat (4) tick();
        read_check(4'h0, "count1_7fff", 16'h7FFF);
        step(0, 1, 2);
        repeat (4) tick();
        read_check(4'h0, "count1_wrap_8000", 16'h8000);

        // Speed: 10 forward steps inside a 100-cycle window, then an empty window
        do_write(4'h8, 16'd100);
        sum0 = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 2);
            sum0++;
        end
        repeat (80) tick();
        read_check(4'hA, "speed1_10", 16'(sum0));
        repeat (100) tick();
        read_check(4'hA, "speed1_empty_window", 16'h0000);

        // Randomized signed speed on both motors in a 200-cycle window
        do_write(4'h8, 16'd200);
        n    = $urandom_range(5, 30);
        sum0 = 0;
        sum1 = 0;
        for (int k = 0; k < n; k++) begin
            d0 = ($urandom_range(0, 1) == 1) ? 1 : -1;
            d1 = ($urandom_range(0, 1) == 1) ? 1 : -1;
            step(0, d0, 1);
            step(1, d1, 1);
            sum0 += d0;
            sum1 += d1;
        end
        repeat (200 - 2 * n) tick();
        spd0 = 16'(sum0);
        spd1 = 16'(sum1);
        read_check(4'hA, "rand_speed1", spd0);
        read_check(4'hC, "rand_speed2", spd1);

        // Window 0 freezes measurement; speeds hold
        do_write(4'h8, 16'd0);
        for (int k = 0; k < 6; k++) step(0, 1, 2);
        repeat (250) tick();
        read_check(4'hA, "win0_speed1_hold", spd0);
        read_check(4'hC, "win0_speed2_hold", spd1);
        read_check(4'h8, "win0_window", 16'h0000);
        do_write(4'h6, 16'h0008);
        read_check(4'hA, "clr_speed1", 16'h0000);
        read_check(4'hC, "clr_speed2", 16'h0000);

        // Randomized position tracking with occasional illegal transitions
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 40; k++) begin
                n = $urandom_range(0, 1);
                if ($urandom_range(0, 15) == 0) begin
                    illegal_move(n);
                end else begin
                    move(n, ($urandom_range(0, 1) == 1) ? 1 : -1);
                end
                repeat ($urandom_range(1, 3)) tick();
            end
            repeat (4) tick();
            read_check(4'h0, "rand_count1", exp_cnt[0]);
            read_check(4'h2, "rand_count2", exp_cnt[1]);
            read_check(4'h4, "rand_status", exp_status());
            do_write(4'h6, 16'h0004);
            exp_err[0] = 1'b0;
            exp_err[1] = 1'b0;
        end

        // Reset mid-operation on motor 2, inputs parked at 11 across release
        for (int k = 0; k < 5; k++) begin
            move(1, 1);
            tick();
            if (k == 2) begin
                #2 rst = 1'b1;
            end
            tick();
        end
        phase[1] = 2;
        drive_enc();
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        repeat (6) tick();
        read_check(4'h2, "post_rst_count2", 16'h0000);
        read_check(4'h0, "post_rst_count1", 16'h0000);
        read_check(4'h4, "post_rst_status", 16'h0000);
        read_check(4'h8, "post_rst_window", 16'd50000);
        step(1, 1, 2);
        repeat (4) tick();
        read_check(4'h2, "post_rst_step_count2", 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peripheral_encoder.md
PERIPHERAL_ENCODER -- requirements
Module: peripheral_encoder

Interface
REQ-001 SHALL have parameter WINDOW_RST, default 16'd50000: reset value of the speed-measurement window, in clk cycles.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port d_in, input, 16: write data from J1.
REQ-005 SHALL have port cs, input, 1: peripheral chip select.
REQ-006 SHALL have port addr, input, 4: 4 LSB of j1_io_addr.
REQ-007 SHALL have port rd, input, 1: read strobe.
REQ-008 SHALL have port wr, input, 1: write strobe.
REQ-009 SHALL have port d_out, output reg, 16: read data.
REQ-010 SHALL have port enc_a, input, 2: quadrature channel A; bit0 = motor 1, bit1 = motor 2.
REQ-011 SHALL have port enc_b, input, 2: quadrature channel B, same bit mapping.

Function
REQ-012 SHALL pass each enc_a/enc_b bit through a 2-flop synchronizer, then a previous-state register, per motor.
REQ-013 SHALL decode x4 quadrature per motor on the synchronized pair {A,B}: 00->10->11->01->00 is +1 (forward); the reverse sequence is -1.
REQ-014 SHALL treat an unchanged {A,B} as no count.
REQ-015 SHALL treat a transition where both A and B change as illegal: no count change, and the sticky err bit for that motor is set.
REQ-016 SHALL reflect an input change in its count register on the 3rd rising clk edge after the change.
REQ-017 SHALL hold position counts count1 and count2 as 16-bit two's complement values that wrap: 16'h7FFF+1 = 16'h8000, 16'h0000-1 = 16'hFFFF, with no saturation.
REQ-018 SHALL update the dir bit per motor on every legal step: 0 = last step forward, 1 = last step reverse.
REQ-019 SHALL free-run a 16-bit window counter from 0 to window-1 in clk cycles.
REQ-020 SHALL, on the cycle the window counter equals window-1: load speed1/speed2 with the signed step sum accumulated during that window, including a step occurring on that same cycle; clear the accumulators; and restart the window counter at 0.
REQ-021 SHALL freeze the window counter and accumulators at 0 when window = 0, with speed1/speed2 holding their values.
REQ-022 SHALL saturate the speed accumulators at 16'h7FFF / 16'h8000.
REQ-023 SHALL use this register map for both read and write:
- 0x0: count1, R.
- 0x2: count2, R.
- 0x4: status, R; bit0 err1, bit1 err2, bit2 dir1, bit3 dir2, other bits 0.
- 0x6: control, W; bit0 clear count1, bit1 clear count2, bit2 clear err1/err2, bit3 clear speed1/speed2 and accumulators.
- 0x8: window, R/W.
- 0xA: speed1, R.
- 0xC: speed2, R.
REQ-024 SHALL perform a write when cs && wr are high at a rising edge.
REQ-025 SHALL ignore writes to read-only or unmapped addresses.
REQ-026 SHALL treat control bits as one-shot; control has no storage.
REQ-027 SHALL register reads: on a rising edge with cs && rd, d_out <= selected register, giving 1-cycle latency.
REQ-028 SHALL drive d_out <= 16'h0000 on any rising edge without cs && rd, and on reads of unmapped or write-only addresses.
REQ-029 SHALL return the pre-update value when a read and a count update coincide.
REQ-030 SHALL give a control clear priority over a simultaneous count step: the result is 0, not ±1.
REQ-031 SHALL restart the window counter at 0, with the accumulators cleared, when window is written.
REQ-032 SHALL not clear status bits on a read of status.
REQ-033 SHALL perform a write only when cs && wr && rd are all asserted together; no read occurs and d_out <= 0.

Reset
REQ-034 SHALL, while rst = 1, asynchronously clear: synchronizers, previous-state registers, count1, count2, err, dir, accumulators, speed1, speed2, window counter and d_out; and set window to WINDOW_RST.
REQ-035 SHALL discard any step in flight when rst asserts mid-operation.
REQ-036 SHALL take the synchronized input value as the previous state after rst deasserts, so no spurious count results from nonzero encoder levels at release.

Verification
REQ-037 SHALL cover the forward drive: 8 forward steps on motor 1, then read 0x0 -> d_out = 16'h0008 one cycle after rd; status bit2 = 0.
REQ-038 SHALL cover reverse steps and wrap: 3 reverse steps on motor 2 from 0 -> count2 = 16'hFFFD, status bit3 = 1; preload count1 to 16'h7FFF by stepping, then 1 forward step -> 16'h8000.
REQ-039 SHALL cover an illegal step: {A,B} 00->11 on motor 1 -> count1 unchanged, status = 16'h0001; write 0x6 = 16'h0004 -> status = 16'h0000.
REQ-040 SHALL cover speed measurement: write window = 100, apply 10 forward steps on motor 1 within one window -> speed1 = 16'h000A at the window end; no steps in the next window -> speed1 = 0.
REQ-041 SHALL cover simultaneous events: a forward step reaching count1 on the same edge as a write 0x6 = 16'h0001 -> count1 = 0.
REQ-042 SHALL cover reset mid-operation: rst pulse during 5 steps of motor 2 with enc inputs held at 11 -> after release, count2 = 0 with no spurious count, and window reads 16'd50000.
